// File: rtl/hpdcache_pkg.sv
// Shared HPDcache geometry: base parameters, derived widths and the common
// set/tag/way/beat/data types used by the refill path.
package hpdcache_pkg;

  localparam int unsigned PA_WIDTH     = 49;
  localparam int unsigned SETS         = 128;
  localparam int unsigned WAYS         = 4;
  localparam int unsigned WORD_WIDTH   = 64;
  localparam int unsigned CL_WORDS     = 8;
  localparam int unsigned ACCESS_WORDS = 4;

  localparam int unsigned BEATS         = CL_WORDS / ACCESS_WORDS;
  localparam int unsigned SET_WIDTH     = $clog2(SETS);
  localparam int unsigned OFFSET_WIDTH  = $clog2(CL_WORDS * WORD_WIDTH / 8);
  localparam int unsigned TAG_WIDTH     = PA_WIDTH - SET_WIDTH - OFFSET_WIDTH;
  // A single-beat line still needs a 1-bit beat index on the RAM interface.
  localparam int unsigned BEAT_WIDTH    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ACCESS_WIDTH  = ACCESS_WORDS * WORD_WIDTH;

  typedef logic [SET_WIDTH-1:0]    hpdcache_set_t;
  typedef logic [TAG_WIDTH-1:0]    hpdcache_tag_t;
  typedef logic [WAYS-1:0]         hpdcache_way_vector_t;
  typedef logic [BEAT_WIDTH-1:0]   hpdcache_refill_beat_t;
  typedef logic [ACCESS_WIDTH-1:0] hpdcache_access_data_t;

endpackage

// File: rtl/hpdcache_refill_sequencer.sv
// Writes one refilled cache line beat-by-beat into the data RAM, then its
// directory entry, arbitrating for the shared RAM port and reporting completion.
module hpdcache_refill_sequencer
  import hpdcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  refill_req_valid_i,
  output logic                  refill_req_ready_o,
  input  hpdcache_set_t         refill_set_i,
  input  hpdcache_way_vector_t  refill_way_i,
  input  hpdcache_tag_t         refill_tag_i,
  input  logic                  mem_resp_valid_i,
  output logic                  mem_resp_ready_o,
  input  hpdcache_access_data_t mem_resp_data_i,
  input  logic                  mem_resp_error_i,
  input  logic                  mem_resp_last_i,
  output logic                  ram_req_o,
  input  logic                  ram_gnt_i,
  output logic                  data_we_o,
  output hpdcache_set_t         data_set_o,
  output hpdcache_way_vector_t  data_way_o,
  output hpdcache_refill_beat_t data_beat_o,
  output hpdcache_access_data_t data_wdata_o,
  output logic                  dir_we_o,
  output hpdcache_set_t         dir_set_o,
  output hpdcache_way_vector_t  dir_way_o,
  output hpdcache_tag_t         dir_tag_o,
  output logic                  dir_valid_o,
  output logic                  done_valid_o,
  output logic                  done_error_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, DATA, DIR, DONE} state_e;

  localparam hpdcache_refill_beat_t BEAT_LAST = hpdcache_refill_beat_t'(BEATS - 1);

  state_e                state_q;
  hpdcache_set_t         set_q;
  hpdcache_way_vector_t  way_q;
  hpdcache_tag_t         tag_q;
  hpdcache_refill_beat_t cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic in_idle, in_data, in_dir, in_done;
  logic xfer, last_cnt;

  assign in_idle  = (state_q == IDLE);
  assign in_data  = (state_q == DATA);
  assign in_dir   = (state_q == DIR);
  assign in_done  = (state_q == DONE);
  assign xfer     = in_data & mem_resp_valid_i & ram_gnt_i;
  assign last_cnt = (cnt_q == BEAT_LAST);

  // A last flag out of step with the beat count is treated as a bus error.
  assign cnt_d = cnt_q + 1'b1;
  assign err_d = err_q | mem_resp_error_i | (mem_resp_last_i != last_cnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      set_q   <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (refill_req_valid_i) begin
            set_q   <= refill_set_i;
            way_q   <= refill_way_i;
            tag_q   <= refill_tag_i;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (last_cnt) state_q <= DIR;
          end
        end
        DIR: begin
          if (ram_gnt_i) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign refill_req_ready_o = in_idle;
  assign busy_o             = ~in_idle;

  assign ram_req_o          = (in_data & mem_resp_valid_i) | in_dir;
  assign mem_resp_ready_o   = in_data & ram_gnt_i;

  assign data_we_o          = xfer;
  assign data_set_o         = set_q;
  assign data_way_o         = way_q;
  assign data_beat_o        = cnt_q;
  assign data_wdata_o       = mem_resp_data_i;

  assign dir_we_o           = in_dir & ram_gnt_i;
  assign dir_set_o          = set_q;
  assign dir_way_o          = way_q;
  assign dir_tag_o          = tag_q;
  assign dir_valid_o        = in_dir & ram_gnt_i & ~err_q;

  assign done_valid_o       = in_done;
  assign done_error_o       = in_done & err_q;

endmodule

// File: doc/hpdcache_refill_sequencer.md
Name: hpdcache_refill_sequencer

Overview:
Sequences one cache-line refill at a time from the memory response channel into the HPDcache data RAM, then the directory. Data is written in ACCESS_WORDS-wide beats. The block requests the shared data/dir RAM port from the core arbiter and stalls on loss of grant. It sits between the MSHR/miss handler (refill request), the memory read-response interface and the core RAM arbiter.

Parameters:
PA_WIDTH, 49, physical address width
SETS, 128, cache sets
WAYS, 4, cache ways
WORD_WIDTH, 64, word width (bits)
CL_WORDS, 8, words per cache line
ACCESS_WORDS, 4, words per RAM access and per memory response beat; must divide CL_WORDS

Derived values:
- BEATS = CL_WORDS/ACCESS_WORDS
- TAG_WIDTH = PA_WIDTH - log2(SETS) - log2(CL_WORDS*WORD_WIDTH/8); 36 at defaults

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
refill_req_valid_i  in  1  refill request valid
refill_req_ready_o  out  1  sequencer idle, accepts request
refill_set_i  in  log2(SETS)  target set
refill_way_i  in  WAYS  target way, one-hot
refill_tag_i  in  TAG_WIDTH  line tag
mem_resp_valid_i  in  1  response beat valid
mem_resp_ready_o  out  1  beat consumed
mem_resp_data_i  in  ACCESS_WORDS*WORD_WIDTH  beat data
mem_resp_error_i  in  1  beat carries bus error
mem_resp_last_i  in  1  last beat of line
ram_req_o  out  1  request data/dir RAM port from arbiter
ram_gnt_i  in  1  RAM port granted this cycle
data_we_o  out  1  data RAM write strobe
data_set_o  out  log2(SETS)  data RAM set
data_way_o  out  WAYS  data RAM way, one-hot
data_beat_o  out  log2(BEATS) (min 1)  chunk index within line
data_wdata_o  out  ACCESS_WORDS*WORD_WIDTH  write data, equal to mem_resp_data_i
dir_we_o  out  1  directory write strobe
dir_set_o  out  log2(SETS)  directory set
dir_way_o  out  WAYS  directory way
dir_tag_o  out  TAG_WIDTH  directory tag
dir_valid_o  out  1  valid bit written to directory
done_valid_o  out  1  refill-complete pulse
done_error_o  out  1  refill completed with error; qualified by done_valid_o
busy_o  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, DATA, DIR, DONE. Registers: set, way, tag, beat counter, sticky err.
- Reset:
  - State IDLE; counter and err cleared.
  - refill_req_ready_o=1; every other output 0.
  - Data, address and tag outputs are don't-care while their strobes are 0.
- IDLE:
  - refill_req_ready_o=1.
  - On valid&ready: capture set, way and tag; counter=0; err=0; go to DATA.
- DATA:
  - ram_req_o = mem_resp_valid_i.
  - mem_resp_ready_o = ram_gnt_i (combinational).
  - data_we_o = mem_resp_valid_i & ram_gnt_i; data_beat_o = counter.
  - Per transfer: counter+1; err |= mem_resp_error_i.
  - Protocol check: mem_resp_last_i must equal (counter==BEATS-1). A mismatch sets err.
  - Transfer at counter==BEATS-1 goes to DIR, regardless of last.
  - No gnt: no transfer, no write, counter holds.
- DIR:
  - ram_req_o=1.
  - On ram_gnt_i: dir_we_o=1 with captured set/way/tag; dir_valid_o = !err; go to DONE.
- DONE:
  - done_valid_o=1 and done_error_o=err for exactly one cycle.
  - Go to IDLE. refill_req_ready_o=0 in this cycle.
- Latency, with gnt always high and beats back-to-back:
  - Accept at cycle 0; data writes at cycles 1..BEATS; dir write at BEATS+1; done at BEATS+2.
  - Next request can be accepted at BEATS+3.
- Data writes are performed even on erroneous beats; the line is left invalid (dir_valid_o=0).
- BEATS==1: a single data write, then DIR.
- mem_resp_ready_o=0 in every state except DATA.
- Refill request while busy: not accepted (ready=0). Requester holds.
- Reset asserted mid-operation: next cycle IDLE, no done pulse, partial line not validated.

Decomposition:
- hpdcache_pkg (shared) holds:
  - the derived constants BEATS and TAG_WIDTH;
  - typedefs hpdcache_set_t, hpdcache_tag_t, hpdcache_way_vector_t, hpdcache_refill_beat_t (counter), hpdcache_access_data_t.
- FSM state enum stays local to the module.
- No sub-module: the FSM and counter fit in a single module.

Test Plan:
- Nominal refill, set=5, way=4'b0010, tag=0x123, 2 beats with gnt=1 -> data_we at cycles 1 and 2 (beat 0, 1), dir_we cycle 3 with dir_valid=1, done cycle 4 with error=0.
- gnt=0 for cycles 1-3, then 1 -> ram_req_o=1 and mem_resp_ready_o=0 while stalled; no data_we_o; beat 0 written at cycle 4; done shifts by 3 cycles.
- mem_resp_error_i=1 on beat 1 -> both beats still written; dir_valid_o=0; done_error_o=1.
- mem_resp_last_i=1 on beat 0 -> err set; dir_valid_o=0; done_error_o=1; sequencer still consumes 2 beats.
- rst_i pulsed during DATA after beat 0 -> next cycle busy_o=0 and refill_req_ready_o=1; no dir_we or done; a new refill completes normally.
- Second refill_req_valid_i held from cycle 1 -> accepted only at cycle 5 (IDLE after DONE); refill_req_ready_o=0 during cycles 1-4.
